restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, giving the operand, result and bus width; the iteration count equals BUS_WIDTH.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the rising clk edge.
REQ-004 SHALL have port inbus, input, BUS_WIDTH, the operand bus: divisor first, then dividend.
REQ-005 SHALL have port beginsig, input, 1, the start request.
REQ-006 SHALL have port locksig, input, 1, the bus ownership; deasserting it aborts or releases the block.
REQ-007 SHALL have port outbus, output, BUS_WIDTH, the result bus: quotient first, then remainder; 0 otherwise.
REQ-008 SHALL have port endsig, output, 1, completion flag.
REQ-009 SHALL have port errsig, output, 1, divide-by-zero flag, valid while endsig=1.

Function
REQ-010 SHALL perform unsigned restoring division, dividend/divisor, giving quotient Q and remainder R, with dividend = Q*divisor + R and R < divisor.
REQ-011 SHALL hold the internal registers M (divisor, BUS_WIDTH), Q (dividend/quotient, BUS_WIDTH), A (partial remainder, BUS_WIDTH+1) and an iteration counter of ceil(log2(BUS_WIDTH)) bits.
REQ-012 SHALL use the states IDLE, LOADM, LOADQ, ITER, OUTQ, OUTR, DONE, each lasting one cycle except ITER (BUS_WIDTH cycles) and IDLE/DONE (held).
REQ-013 IDLE: outbus=0, endsig=0, errsig=0; beginsig=1 and locksig=1 at an edge -> LOADM.
REQ-014 LOADM: M<=inbus, A<=0, counter<=0 -> LOADQ.
REQ-015 LOADQ, M!=0: Q<=inbus -> ITER.
REQ-016 LOADQ, M=0: Q<=all ones, A<=inbus, error flag<=1 -> OUTQ, with no ITER cycles.
REQ-017 ITER, per cycle:
  - form S = {A[BUS_WIDTH-1:0], Q} shifted left by 1; take the upper BUS_WIDTH+1 bits as T.
  - if T >= M (unsigned, BUS_WIDTH+1 bits): A<=T-M and Q[0]<=1.
  - else: A<=T and Q[0]<=0 (restore in the same cycle).
  - Q[BUS_WIDTH-1:1] SHALL take the shifted Q bits in both cases.
  - counter++.
REQ-018 ITER SHALL exit to OUTQ after the cycle in which counter=BUS_WIDTH-1, giving exactly BUS_WIDTH iterations.
REQ-019 OUTQ: outbus=Q -> OUTR.
REQ-020 OUTR: outbus=A[BUS_WIDTH-1:0] -> DONE.
REQ-021 DONE: endsig=1, errsig=error flag, outbus=0; stays in DONE while locksig=1; locksig=0 -> IDLE.
REQ-022 With BUS_WIDTH=8 and the start edge counted as edge 0:
  - M is captured at edge 1 and Q at edge 2.
  - ITER occupies edges 3-10.
  - outbus carries the quotient after edge 10 and the remainder after edge 11.
  - endsig rises after edge 12.
REQ-023 locksig=0 in any state except IDLE or DONE SHALL abort to IDLE at the next edge; outputs SHALL follow IDLE values and no endsig pulse SHALL occur.
REQ-024 beginsig SHALL be ignored in every state except IDLE; a new operation requires a return to IDLE first.
REQ-025 Arithmetic SHALL never overflow: A is BUS_WIDTH+1 bits, and after a subtraction A[BUS_WIDTH] SHALL be 0.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE and clear M, Q, A, the counter and the error flag to 0, regardless of state, including mid-ITER.
REQ-027 While in reset and for the cycle after release, outbus=0, endsig=0, errsig=0.
REQ-028 rst SHALL take priority over beginsig and locksig at the same edge.

Verification
REQ-029 divisor 0x07, dividend 0x64 -> outbus 0x0E (OUTQ), then 0x02 (OUTR); endsig=1, errsig=0; endsig rises after edge 12.
REQ-030 divisor 0x01, dividend 0xFF -> 0xFF, 0x00; divisor 0xFF, dividend 0xFF -> 0x01, 0x00; divisor 0x0A, dividend 0x05 -> 0x00, 0x05.
REQ-031 divisor 0x00, dividend 0x2A -> 0xFF, 0x2A; errsig=1 with endsig; DONE reached 3 edges after LOADQ.
REQ-032 rst=1 during the 4th ITER cycle -> IDLE next edge, all outputs 0; a fresh operation afterwards with 0x03 / 0x0A -> 0x03, 0x01.
REQ-033 locksig=0 during ITER -> IDLE next edge with no endsig pulse; beginsig held at 1 throughout DONE -> no restart until locksig=0 returns the block to IDLE.
REQ-034 Random unsigned operand pairs (>=1000, including divisor 0) checked against a reference model for quotient, remainder, errsig and exact cycle timing.

Source files
------------

// File: rtl/restoring_divider_if.sv
// restoring_divider_if: operand/result bus and handshake between a bus owner and the divider
interface restoring_divider_if #(parameter int BUS_WIDTH = 8);
   logic [BUS_WIDTH-1:0] inbus;
   logic                 beginsig;
   logic                 locksig;
   logic [BUS_WIDTH-1:0] outbus;
   logic                 endsig;
   logic                 errsig;
   modport master (output inbus, beginsig, locksig, input outbus, endsig, errsig);
   modport slave  (input inbus, beginsig, locksig, output outbus, endsig, errsig);
endinterface

// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle unsigned restoring divider, one quotient bit per ITER cycle
module restoring_divider #(
   parameter int BUS_WIDTH = 8
) (
   input logic                clk,
   input logic                rst,
   restoring_divider_if.slave bus
);
   localparam int W  = BUS_WIDTH;
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   typedef enum logic [2:0] {IDLE, LOADM, LOADQ, ITER, OUTQ, OUTR, DONE} state_t;
   state_t         state_q, state_d;
   logic [W-1:0]   m_q, m_d, q_q, q_d, out_q, out_d;
   logic [W:0]     a_q, a_d, t;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           err_q, err_d, end_q, end_d, errsig_q, errsig_d, ge, unused_msb;
   assign t          = {a_q[W-1:0], q_q[W-1]};
   assign ge         = t >= {1'b0, m_q};
   assign unused_msb = a_q[W];
   assign bus.outbus = out_q;
   assign bus.endsig = end_q;
   assign bus.errsig = errsig_q;
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      q_d     = q_q;
      a_d     = a_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE:  state_d = (bus.beginsig && bus.locksig) ? LOADM : IDLE;
         LOADM: begin
            m_d     = bus.inbus;
            a_d     = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = LOADQ;
         end
         LOADQ: begin
            q_d     = (m_q == '0) ? '1 : bus.inbus;
            a_d     = (m_q == '0) ? {1'b0, bus.inbus} : a_q;
            err_d   = (m_q == '0);
            state_d = (m_q == '0) ? OUTQ : ITER;
         end
         ITER: begin
            a_d     = ge ? t - {1'b0, m_q} : t;
            q_d     = {q_q[W-2:0], ge};
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(W - 1)) ? OUTQ : ITER;
         end
         OUTQ:    state_d = OUTR;
         OUTR:    state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (!bus.locksig) state_d = IDLE;
      out_d    = (state_d == OUTQ) ? q_d : (state_d == OUTR) ? a_d[W-1:0] : '0;
      end_d    = (state_d == DONE);
      errsig_d = (state_d == DONE) && err_d;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         m_q      <= '0;
         q_q      <= '0;
         a_q      <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         out_q    <= '0;
         end_q    <= 1'b0;
         errsig_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         q_q      <= q_d;
         a_q      <= a_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         out_q    <= out_d;
         end_q    <= end_d;
         errsig_q <= errsig_d;
      end
   end
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed and reference-model checks of restoring_divider results and timing
module tb_restoring_divider;
   localparam int W = 8;
   logic clk, rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [W-1:0] obs_out [0:15];
   logic         obs_end [0:15];
   logic         obs_err [0:15];
   restoring_divider_if #(.BUS_WIDTH(W)) bus ();
   restoring_divider #(.BUS_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic run_op(input logic [W-1:0] dv, input logic [W-1:0] dd, input int ab_at, input bit ab_rst);
      bus.beginsig = 1'b1;
      bus.locksig  = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk);
         @(negedge clk);
         obs_out[k] = bus.outbus;
         obs_end[k] = bus.endsig;
         obs_err[k] = bus.errsig;
         bus.beginsig = 1'b0;
         if (k == 0) bus.inbus = dv;
         if (k == 1) bus.inbus = dd;
         if (rst) rst = 1'b0;
         if (k + 1 == ab_at) begin
            if (ab_rst) rst = 1'b1;
            else bus.locksig = 1'b0;
         end
      end
   endtask
   task automatic release_bus();
      bus.locksig  = 1'b0;
      bus.beginsig = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic test_reset();
      rst = 1'b1;
      bus.beginsig = 1'b1;
      bus.locksig  = 1'b1;
      bus.inbus    = 8'h55;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.outbus !== 8'h00 || bus.endsig !== 1'b0 || bus.errsig !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: out=%h end=%b err=%b, want 00/0/0", bus.outbus, bus.endsig, bus.errsig);
      end
      bus.beginsig = 1'b0;
      bus.locksig  = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.outbus !== 8'h00 || bus.endsig !== 1'b0 || bus.errsig !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: out=%h end=%b err=%b, want 00/0/0", bus.outbus, bus.endsig, bus.errsig);
      end
   endtask
   task automatic test_basic();
      run_op(8'h07, 8'h64, 99, 1'b0);
      n_checks++;
      if (obs_out[9] !== 8'h00) begin n_fail++; $display("FAIL basic_iter_out: got %h want 00", obs_out[9]); end
      n_checks++;
      if (obs_out[10] !== 8'h0E) begin n_fail++; $display("FAIL basic_quot: got %h want 0e", obs_out[10]); end
      n_checks++;
      if (obs_out[11] !== 8'h02) begin n_fail++; $display("FAIL basic_rem: got %h want 02", obs_out[11]); end
      n_checks++;
      if (obs_end[11] !== 1'b0 || obs_end[12] !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_end_edge: end@11=%b end@12=%b want 0/1", obs_end[11], obs_end[12]);
      end
      n_checks++;
      if (obs_err[12] !== 1'b0 || obs_out[12] !== 8'h00) begin
         n_fail++;
         $display("FAIL basic_done_out: err=%b out=%h want 0/00", obs_err[12], obs_out[12]);
      end
      release_bus();
      n_checks++;
      if (bus.endsig !== 1'b0) begin n_fail++; $display("FAIL basic_release: end=%b want 0", bus.endsig); end
   endtask
   task automatic test_vectors();
      logic [W-1:0] dv [0:3] = '{8'h01, 8'hFF, 8'h0A, 8'h03};
      logic [W-1:0] dd [0:3] = '{8'hFF, 8'hFF, 8'h05, 8'h0A};
      logic [W-1:0] eq [0:3] = '{8'hFF, 8'h01, 8'h00, 8'h03};
      logic [W-1:0] er [0:3] = '{8'h00, 8'h00, 8'h05, 8'h01};
      for (int i = 0; i < 4; i++) begin
         run_op(dv[i], dd[i], 99, 1'b0);
         n_checks++;
         if (obs_out[10] !== eq[i] || obs_out[11] !== er[i]) begin
            n_fail++;
            $display("FAIL vec%0d: q=%h r=%h want %h/%h", i, obs_out[10], obs_out[11], eq[i], er[i]);
         end
         n_checks++;
         if (obs_end[12] !== 1'b1 || obs_err[12] !== 1'b0) begin
            n_fail++;
            $display("FAIL vec%0d_end: end=%b err=%b want 1/0", i, obs_end[12], obs_err[12]);
         end
         release_bus();
      end
   endtask
   task automatic test_div_zero();
      run_op(8'h00, 8'h2A, 99, 1'b0);
      n_checks++;
      if (obs_out[2] !== 8'hFF || obs_out[3] !== 8'h2A) begin
         n_fail++;
         $display("FAIL dz_out: q=%h r=%h want ff/2a", obs_out[2], obs_out[3]);
      end
      n_checks++;
      if (obs_end[3] !== 1'b0 || obs_end[4] !== 1'b1 || obs_err[4] !== 1'b1) begin
         n_fail++;
         $display("FAIL dz_end: end@3=%b end@4=%b err@4=%b want 0/1/1", obs_end[3], obs_end[4], obs_err[4]);
      end
      release_bus();
      n_checks++;
      if (bus.errsig !== 1'b0) begin n_fail++; $display("FAIL dz_release: err=%b want 0", bus.errsig); end
   endtask
   task automatic test_reset_mid_iter();
      bit ok = 1'b1;
      run_op(8'h03, 8'h0A, 6, 1'b1);
      for (int k = 0; k < 16; k++)
         if (obs_end[k] !== 1'b0 || obs_err[k] !== 1'b0 || (k >= 6 && obs_out[k] !== 8'h00)) ok = 1'b0;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rst_abort: out@10=%h end@12=%b want 00/0", obs_out[10], obs_end[12]); end
      release_bus();
      run_op(8'h03, 8'h0A, 99, 1'b0);
      n_checks++;
      if (obs_out[10] !== 8'h03 || obs_out[11] !== 8'h01 || obs_end[12] !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_fresh: q=%h r=%h end=%b want 03/01/1", obs_out[10], obs_out[11], obs_end[12]);
      end
      release_bus();
   endtask
   task automatic test_lock_abort();
      bit ok = 1'b1;
      run_op(8'h05, 8'h4D, 5, 1'b0);
      for (int k = 0; k < 16; k++)
         if (obs_end[k] !== 1'b0 || (k >= 5 && obs_out[k] !== 8'h00)) ok = 1'b0;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL lock_abort: out@10=%h end@12=%b want 00/0", obs_out[10], obs_end[12]); end
      run_op(8'h05, 8'h4D, 99, 1'b0);
      n_checks++;
      if (obs_out[10] !== 8'h0F || obs_out[11] !== 8'h02) begin
         n_fail++;
         $display("FAIL lock_fresh: q=%h r=%h want 0f/02", obs_out[10], obs_out[11]);
      end
      release_bus();
   endtask
   task automatic test_begin_ignored();
      bit ok = 1'b1;
      run_op(8'h09, 8'hC8, 99, 1'b0);
      n_checks++;
      if (obs_out[10] !== 8'h16 || obs_out[11] !== 8'h02) begin
         n_fail++;
         $display("FAIL bi_result: q=%h r=%h want 16/02", obs_out[10], obs_out[11]);
      end
      bus.beginsig = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.endsig !== 1'b1 || bus.outbus !== 8'h00) ok = 1'b0;
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL bi_done_hold: end=%b out=%h want 1/00", bus.endsig, bus.outbus); end
      bus.locksig = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.endsig !== 1'b0) begin n_fail++; $display("FAIL bi_unlock: end=%b want 0", bus.endsig); end
      release_bus();
   endtask
   task automatic test_random();
      logic [W-1:0] dv, dd, eq, er;
      bit           ee;
      int           qe;
      for (int i = 0; i < 1000; i++) begin
         dv = (i % 16 == 0) ? 8'h00 : W'($urandom_range(1, 255));
         dd = W'($urandom_range(0, 255));
         ee = (dv == 8'h00);
         eq = ee ? 8'hFF : dd / dv;
         er = ee ? dd : dd % dv;
         qe = ee ? 2 : 10;
         run_op(dv, dd, 99, 1'b0);
         n_checks++;
         if (obs_out[qe] !== eq || obs_out[qe+1] !== er) begin
            n_fail++;
            $display("FAIL rnd_result %h/%h: q=%h r=%h want %h/%h", dd, dv, obs_out[qe], obs_out[qe+1], eq, er);
         end
         n_checks++;
         if (obs_end[qe+1] !== 1'b0 || obs_end[qe+2] !== 1'b1 || obs_err[qe+2] !== ee) begin
            n_fail++;
            $display("FAIL rnd_end %h/%h: end=%b%b err=%b want 01/%b", dd, dv, obs_end[qe+1], obs_end[qe+2], obs_err[qe+2], ee);
         end
         release_bus();
      end
   endtask
   initial begin
      rst = 1'b0;
      bus.inbus = '0;
      bus.beginsig = 1'b0;
      bus.locksig = 1'b0;
      test_reset();
      test_basic();
      test_vectors();
      test_div_zero();
      test_reset_mid_iter();
      test_lock_abort();
      test_begin_ignored();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
